div_issue_ctrl: RTL

- EX-stage controller that issues integer divide/modulo ops to the iterative 32-bit divider and returns the selected result to the pipeline.
- Owns the request side of the divider interface: holds the request level, keeps operands stable, selects quotient or remainder, and stalls EX.
- Handles pipeline flush while a divide is in flight by draining the divider. The divider cannot be aborted: dropping its request level freezes its iteration count mid-operation.

---
 rtl/div_issue_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : EX-stage issue controller for an iterative 32-bit divider.
//            Latches one divide/modulo op and holds the divider request level
//            and operands until the divider reports completion. It then
//            presents the quotient or remainder to the pipeline and stalls EX
//            while the op is outstanding. A flush while the divider is
//            running drains it, because the divider cannot be aborted.
// Ports    : clk/reset                      - clock, sync active-high reset
//            in_valid/in_op/in_src1/in_src2 - op from EX, in_ready = accept
//            flush                          - discard current/pending op
//            out_valid/out_ready/out_result - result handshake
//            ex_stall                       - hold EX
//            div_en/div_signed/div_x/div_y  - divider request side
//            div_q/div_r/div_complete       - divider response side
//            div_err                        - sticky watchdog error
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int DIV_CYCLES = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        ex_stall,
    output logic        div_en,
    output logic        div_signed,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_complete,
    output logic        div_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [6:0] C_WDOG_LIMIT = 7'(DIV_CYCLES);
    localparam logic [5:0] C_WDOG_MAX   = 6'h3F;

    state_t      state_q, state_d;
    logic        rem_q;          // op[0]: select remainder instead of quotient
    logic        signed_q;
    logic [31:0] x_q, y_q;
    logic [31:0] result_q;
    logic        err_q;
    logic [5:0]  wdog_q;

    logic        w_accept;
    logic        w_capture;
    logic        w_wdog_clr;
    logic        w_wdog_trip;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_wdog_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    w_accept   = 1'b1;
                    w_wdog_clr = 1'b1;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (div_complete) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        w_capture = 1'b1;
                        state_d   = S_DONE;
                    end
                end else if (flush) begin
                    // Divider must run to completion; wait for it in DRAIN.
                    w_wdog_clr = 1'b1;
                    state_d    = S_DRAIN;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_complete) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request level is a pure function of state, so div_complete (which the
    // divider derives partly from div_en) never feeds back combinationally.
    assign div_en    = (state_q == S_BUSY) || (state_q == S_DRAIN);
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign ex_stall  = (in_valid && !in_ready) || div_en;

    // The watchdog trips on the cycle that would be the DIV_CYCLES-th cycle
    // of div_en without completion; the counter saturates so it cannot wrap.
    assign w_wdog_trip = div_en && !div_complete &&
                         (({1'b0, wdog_q} + 7'd1) >= C_WDOG_LIMIT);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rem_q    <= 1'b0;
            signed_q <= 1'b0;
            x_q      <= 32'd0;
            y_q      <= 32'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
            wdog_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                rem_q    <= in_op[0];
                signed_q <= ~in_op[1];
                x_q      <= in_src1;
                y_q      <= in_src2;
            end
            if (w_capture) begin
                result_q <= rem_q ? div_r : div_q;
            end
            if (w_wdog_clr) begin
                wdog_q <= 6'd0;
            end else if (div_en && (wdog_q != C_WDOG_MAX)) begin
                wdog_q <= wdog_q + 6'd1;
            end
            if (w_wdog_trip) begin
                err_q <= 1'b1;
            end
        end
    end

    assign div_signed = signed_q;
    assign div_x      = x_q;
    assign div_y      = y_q;
    assign out_result = result_q;
    assign div_err    = err_q;

endmodule
`default_nettype wire
